// File: rtl/tone_pkg.sv
// Shared constants and helpers for the tone mixer.
// Register map codes and sample saturation.
package tone_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_AMP    = 2'd2;

  function automatic logic signed [63:0] sat_to_sample(
    input logic signed [63:0] sum,
    input int unsigned        sw = 24
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (sw - 1));
    if (sum > hi)
      return hi;
    else if (sum < lo)
      return lo;
    return sum;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One pulse-wave channel: registers, period counter and
// signed +/-amp contribution.
module tone_channel
  import tone_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int AMP_W    = 16,
  parameter int SUM_W    = 27
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we_period,
  input  logic                       we_duty,
  input  logic                       we_amp,
  input  logic [PERIOD_W-1:0]        data,
  output logic signed [SUM_W-1:0]    contrib
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] duty;
  logic [AMP_W-1:0]    amp;
  logic [PERIOD_W-1:0] cnt;
  logic                silent;
  logic                high;
  logic signed [SUM_W-1:0] mag;

  assign silent = (period == '0);
  assign high   = (cnt < duty);
  assign mag    = $signed(SUM_W'(amp));

  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      duty   <= '0;
      amp    <= '0;
      cnt    <= '0;
    end else begin
      if (we_period) period <= data;
      if (we_duty)   duty   <= data;
      if (we_amp)    amp    <= AMP_W'(data);
      // A period rewrite restarts the waveform at phase 0
      if (we_period || silent)
        cnt <= '0;
      else if (cnt >= period - PERIOD_W'(1))
        cnt <= '0;
      else
        cnt <= cnt + PERIOD_W'(1);
    end
  end

  always_comb begin
    contrib = '0;
    if (!silent)
      contrib = high ? mag : -mag;
  end

endmodule

// File: rtl/tone_mixer.sv
// Multi-channel pulse tone generator with saturating mix
// and tick-driven output sample register.
module tone_mixer
  import tone_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SAMPLE_W = 24,
  parameter int PERIOD_W = 16,
  parameter int AMP_W    = 22,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SUM_W   = SAMPLE_W + $clog2(CHANNELS) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_addr,
  input  logic [PERIOD_W-1:0] cfg_data,
  input  logic                sample_tick,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid
);

  logic signed [SUM_W-1:0] contrib [CHANNELS];
  logic signed [SUM_W-1:0] mix;
  logic signed [63:0]      sat_full;
  logic                    sat_unused;

  logic wr_period;
  logic wr_duty;
  logic wr_amp;

  assign wr_period = cfg_we && (cfg_addr == ADDR_PERIOD);
  assign wr_duty   = cfg_we && (cfg_addr == ADDR_DUTY);
  assign wr_amp    = cfg_we && (cfg_addr == ADDR_AMP);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit = (32'(cfg_ch) == i);

    tone_channel #(
      .PERIOD_W (PERIOD_W),
      .AMP_W    (AMP_W),
      .SUM_W    (SUM_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .we_period (hit && wr_period),
      .we_duty   (hit && wr_duty),
      .we_amp    (hit && wr_amp),
      .data      (cfg_data),
      .contrib   (contrib[i])
    );
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < CHANNELS; i++)
      mix = mix + contrib[i];
  end

  assign sat_full   = sat_to_sample(64'(mix), SAMPLE_W);
  assign sat_unused = ^sat_full[63:SAMPLE_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_tick;
      if (sample_tick)
        sample <= sat_full[SAMPLE_W-1:0];
    end
  end

endmodule

// File: tb/tb_tone_mixer.sv
// Self-checking bench for tone_mixer against a
// cycle-level behavioural model of the channel rules.
module tb_tone_mixer;

  localparam int CH = 4;
  localparam int SW = 24;
  localparam int PW = 22;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_addr;
  logic [PW-1:0] cfg_data;
  logic          sample_tick;
  logic [SW-1:0] sample;
  logic          sample_valid;

  int n_cmp = 0;
  int n_bad = 0;

  longint m_per  [CH];
  longint m_duty [CH];
  longint m_amp  [CH];
  longint m_cnt  [CH];
  longint exp_sample;
  longint exp_valid;

  longint pat [4] = '{100, 100, -100, -100};

  tone_mixer #(
    .CHANNELS (CH),
    .SAMPLE_W (SW),
    .PERIOD_W (PW),
    .AMP_W    (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .sample_tick  (sample_tick),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, longint got, longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_mix();
    longint s;
    longint hi;
    longint lo;
    s  = 0;
    hi = (longint'(1) << (SW - 1)) - 1;
    lo = -(longint'(1) << (SW - 1));
    for (int c = 0; c < CH; c++) begin
      if (m_per[c] != 0)
        s += (m_cnt[c] < m_duty[c]) ? m_amp[c] : -m_amp[c];
    end
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  task automatic step(bit rst, bit we, int ch, int addr,
                      longint data, bit tick);
    longint mix;
    reset       = rst;
    cfg_we      = we;
    cfg_ch      = 2'(ch);
    cfg_addr    = 2'(addr);
    cfg_data    = PW'(data);
    sample_tick = tick;
    mix = model_mix();
    @(posedge clk);
    #1;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_per[c] = 0; m_duty[c] = 0;
        m_amp[c] = 0; m_cnt[c]  = 0;
      end
      exp_sample = 0;
      exp_valid  = 0;
    end else begin
      for (int c = 0; c < CH; c++)
        m_cnt[c] = (m_per[c] == 0) ? 0 : (m_cnt[c] + 1) % m_per[c];
      if (we && ch < CH) begin
        case (addr)
          0: begin m_per[ch] = data % (1 << PW); m_cnt[ch] = 0; end
          1: m_duty[ch] = data % (1 << PW);
          2: m_amp[ch]  = data % (1 << AW);
          default: ;
        endcase
      end
      exp_valid = tick;
      if (tick) exp_sample = mix;
    end
    check("valid", longint'(sample_valid), exp_valid);
    check("sample", $signed(sample), exp_sample);
  endtask

  task automatic wr(int ch, int addr, longint data);
    step(0, 1, ch, addr, data, 0);
  endtask

  task automatic tick_only();
    step(0, 0, 0, 0, 0, 1);
  endtask

  int ph;

  initial begin
    step(1, 0, 0, 0, 0, 0);
    check("rst_sample", $signed(sample), 0);
    check("rst_valid", longint'(sample_valid), 0);

    // idle ticks produce zero samples
    for (int k = 0; k < 4; k++) begin
      tick_only();
      check("idle_zero", $signed(sample), 0);
    end
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    check("rst_over_tick", longint'(sample_valid), 0);

    // basic 2-of-4 duty pattern on ch0
    wr(0, 2, 100);
    wr(0, 1, 2);
    wr(0, 0, 4);
    for (int k = 0; k < 8; k++) begin
      tick_only();
      check("pat4", $signed(sample), pat[k % 4]);
    end

    // opposing constant channels
    step(1, 0, 0, 0, 0, 0);
    wr(0, 2, 50); wr(0, 1, 0); wr(0, 0, 6);
    wr(1, 2, 30); wr(1, 1, 6); wr(1, 0, 6);
    for (int k = 0; k < 8; k++) begin
      tick_only();
      check("mix_m20", $signed(sample), -20);
    end

    // saturation both ways
    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < CH; c++) begin
      wr(c, 2, 64'h3FFFFF);
      wr(c, 1, 1);
      wr(c, 0, 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick_only();
      check("sat_hi", $signed(sample), 8388607);
    end
    for (int c = 0; c < CH; c++) wr(c, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick_only();
      check("sat_lo", $signed(sample), -8388608);
    end

    // period rewrite coincident with a tick
    step(1, 0, 0, 0, 0, 0);
    wr(0, 2, 100);
    wr(0, 1, 2);
    wr(0, 0, 4);
    for (int k = 0; k < 6; k++) tick_only();
    step(0, 1, 0, 0, 4, 1);
    check("rewrite_pre", $signed(sample), -100);
    tick_only();
    check("rewrite_post", $signed(sample), 100);

    // ignored address leaves waveform intact
    step(0, 1, 0, 3, 1, 1);
    check("addr3_tick", $signed(sample), pat[1]);
    ph = 2;
    for (int k = 0; k < 20; k++) begin
      tick_only();
      check("addr3_hold", $signed(sample), pat[ph % 4]);
      ph++;
    end

    // randomized traffic
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      int     a;
      longint d;
      a = $urandom_range(0, 3);
      case (a)
        0: d = $urandom_range(0, 12);
        1: d = $urandom_range(0, 14);
        default: d = $urandom_range(0, (1 << AW) - 1);
      endcase
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, CH - 1),
           a, d,
           $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
